// File: rtl/irq_pkg.sv
// Shared types and constants for the four-source interrupt request collector.
package irq_pkg;
  localparam int NUM_SRC = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] irq_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } irq_state_t;
endpackage

// File: rtl/prio_enc4.sv
// Combinational 4:2 priority encoder; bit 3 has the highest priority.
module prio_enc4
  import irq_pkg::*;
(
  input  logic [3:0] req,
  output irq_idx_t   idx,
  output logic       valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    casez (req)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/irq_req_collector.sv
// Synchronises four request lines, latches them as pending (edge or level),
// and offers the highest-priority masked source over a valid/ready handshake.
module irq_req_collector
  import irq_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [NUM_SRC-1:0] sw_clr,
  output logic [NUM_SRC-1:0] pend_o,
  output logic [NUM_SRC-1:0] ovf_o,
  output logic               req_valid,
  output irq_idx_t           req_idx,
  input  logic               req_ready
);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] hist_q, sync, rise;
  logic [NUM_SRC-1:0] pend_q, pend_d, ovf_q, ovf_d;
  logic [NUM_SRC-1:0] acc_hit, clr;
  logic               accept, enc_valid;
  irq_idx_t           enc_idx, idx_q, idx_d;
  irq_state_t         state_q, state_d;
  logic               vld_q, vld_d;

  // Synchroniser chain plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      hist_q <= sync;
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign rise   = sync & ~hist_q;
  assign accept = vld_q & req_ready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign acc_hit[i] = accept && (idx_q == irq_idx_t'(i));
  end

  assign clr = sw_clr | acc_hit;

  // Edge mode: a same-cycle rise beats any clear. Level mode follows sync.
  assign pend_d = (edge_mode & (rise | (pend_q & ~clr))) | (~edge_mode & sync);
  assign ovf_d  = (edge_mode & rise & pend_q) | (ovf_q & ~sw_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  prio_enc4 u_enc (
    .req   (pend_q & mask),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // The offered index is captured once in IDLE and frozen through OFFER.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          idx_d   = enc_idx;
          vld_d   = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (req_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  assign pend_o    = pend_q;
  assign ovf_o     = ovf_q;
  assign req_valid = vld_q;
  assign req_idx   = idx_q;

endmodule

// File: tb/tb_irq_req_collector.sv
// Directed, table-driven bench for irq_req_collector (default depth 2).
module tb_irq_req_collector;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in, edge_mode, mask, sw_clr;
  logic [3:0] pend_o, ovf_o;
  logic       req_valid, req_ready;
  irq_idx_t   req_idx;

  int n_chk  = 0;
  int n_fail = 0;

  irq_req_collector #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .mask      (mask),
    .sw_clr    (sw_clr),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready)
  );

  always #5 clk = ~clk;

  // Each row is applied for one clock; outputs are checked after that edge.
  typedef struct {
    string      tag;
    logic       rn;
    logic [3:0] irq, edm, msk, clr;
    logic       rdy;
    logic [3:0] e_pend, e_ovf;
    logic       e_vld;
    logic [1:0] e_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input string tag, input logic rn,
                             input logic [3:0] irq, input logic [3:0] edm,
                             input logic [3:0] msk, input logic [3:0] clr,
                             input logic rdy, input logic [3:0] ep,
                             input logic [3:0] eo, input logic ev,
                             input logic [1:0] ei);
    vec_t r;
    r.tag = tag; r.rn = rn; r.irq = irq; r.edm = edm; r.msk = msk;
    r.clr = clr; r.rdy = rdy; r.e_pend = ep; r.e_ovf = eo; r.e_vld = ev;
    r.e_idx = ei;
    return r;
  endfunction

  task automatic check(input string name, input logic [10:0] act,
                       input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pend=%h ovf=%h vld=%b idx=%0d, want pend=%h ovf=%h vld=%b idx=%0d",
               name, act[10:7], act[6:3], act[2], act[1:0],
               exp[10:7], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    // Reset with lines toggling, release, then pend=F at edge 3; clear.
    vecs.push_back(v("rst",  0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("rst",  1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("rst",  1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("rst",  1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'hF, 4'h0, 0, 0));
    vecs.push_back(v("rst",  1, 4'h0, 4'hF, 4'h0, 4'hF, 0, 4'h0, 4'h0, 0, 0));
    // Single edge on bit 1, consumer always ready.
    vecs.push_back(v("one",  0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("one",  1, 4'h2, 4'hF, 4'hF, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("one",  1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("one",  1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h2, 4'h0, 0, 0));
    vecs.push_back(v("one",  1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h2, 4'h0, 1, 1));
    vecs.push_back(v("one",  1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h0, 4'h0, 0, 1));
    // Priority and offer stability.
    vecs.push_back(v("prio", 0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("prio", 1, 4'h5, 4'hF, 4'hF, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'h5, 4'h0, 0, 0));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'h5, 4'h0, 1, 2));
    vecs.push_back(v("prio", 1, 4'h8, 4'hF, 4'hF, 4'h0, 0, 4'h5, 4'h0, 1, 2));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'h5, 4'h0, 1, 2));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'hD, 4'h0, 1, 2));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'hD, 4'h0, 1, 2));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h9, 4'h0, 0, 2));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h9, 4'h0, 1, 3));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h1, 4'h0, 0, 3));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h1, 4'h0, 1, 0));
    vecs.push_back(v("prio", 1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    // Masking: pending but masked, then unmask; mask drop during offer.
    vecs.push_back(v("mask", 0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("mask", 1, 4'h4, 4'hF, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("mask", 1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("mask", 1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 4'h4, 4'h0, 0, 0));
    vecs.push_back(v("mask", 1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 4'h4, 4'h0, 0, 0));
    vecs.push_back(v("mask", 1, 4'h0, 4'hF, 4'h4, 4'h0, 0, 4'h4, 4'h0, 1, 2));
    vecs.push_back(v("mask", 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 2));
    // Overflow, set-beats-accept collision, sw_clr of pend and ovf.
    vecs.push_back(v("ovf",  0, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("ovf",  1, 4'h1, 4'hF, 4'h1, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h0, 0, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h0, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h1, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h0, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h0, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h1, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h1, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h1, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 0, 4'h1, 4'h1, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 1, 4'h1, 4'h1, 0, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h1, 0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(v("ovf",  1, 4'h0, 4'hF, 4'h1, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    // Level mode bit 3 held high: re-offered every 2 cycles.
    vecs.push_back(v("lvl",  0, 4'h0, 4'h0, 4'h8, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h0, 1, 4'h0, 4'h0, 0, 0));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h0, 1, 4'h8, 4'h0, 0, 0));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h0, 1, 4'h8, 4'h0, 1, 3));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h0, 1, 4'h8, 4'h0, 0, 3));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h4, 1, 4'h8, 4'h0, 1, 3));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h8, 1, 4'h8, 4'h0, 0, 3));
    vecs.push_back(v("lvl",  1, 4'h8, 4'h0, 4'h8, 4'h0, 0, 4'h8, 4'h0, 1, 3));

    rst_n = 1'b0; irq_in = '0; edge_mode = '0; mask = '0; sw_clr = '0;
    req_ready = 1'b0;
    @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      rst_n     = vecs[k].rn;
      irq_in    = vecs[k].irq;
      edge_mode = vecs[k].edm;
      mask      = vecs[k].msk;
      sw_clr    = vecs[k].clr;
      req_ready = vecs[k].rdy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d]", vecs[k].tag, k),
            {pend_o, ovf_o, req_valid, req_idx},
            {vecs[k].e_pend, vecs[k].e_ovf, vecs[k].e_vld, vecs[k].e_idx});
    end

    // Reset mid-offer drops the offer without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    check("rst_mid_offer", {pend_o, ovf_o, req_valid, req_idx}, 11'd0);

    // Masked level source stays quiet; sw_clr has no effect in level mode.
    @(negedge clk);
    rst_n = 1'b1; irq_in = 4'h2; edge_mode = 4'h0; mask = 4'h0; sw_clr = 4'h2;
    repeat (4) @(negedge clk);
    check("lvl_masked_clr", {pend_o, ovf_o, req_valid, req_idx},
          {4'h2, 4'h0, 1'b0, 2'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
